// File: rtl/encoder8to3_serial.sv
// Serialises a one-or-more-hot 8-bit vector into the 3-bit indices of its set bits, MSB first (LSB first with ENCODER8TO3_LSB_FIRST_EN).
// Latency: first index valid the cycle after acceptance; one index per out handshake, k set bits drain in k cycles plus one idle cycle.
// Backpressure: out_ready low holds out/out_last/out_valid stable; in_ready stays low until the whole vector has drained.
module encoder8to3_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       in_ready,
  output logic       out_valid,
  output logic [2:0] out,
  output logic       out_last,
  input  logic       out_ready,
  output logic       out_empty
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pending;
  logic [7:0] pending_nxt;
  logic       empty_nxt;
  logic       alive;
  logic [2:0] idx;
  logic       accept;
  logic       take;

  // Pick the index of the highest-priority bit still pending
  always_comb begin
    idx = 3'd0;
`ifdef ENCODER8TO3_LSB_FIRST_EN
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) idx = 3'(i);
    end
`else
    for (int i = 0; i < 8; i++) begin
      if (pending[i]) idx = 3'(i);
    end
`endif
  end

  // All outputs decode from registered state only
  assign out       = idx;
  assign out_last  = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);
  assign out_valid = (state == DRAIN);
  // alive keeps in_ready low through reset and on the edge where reset releases
  assign in_ready  = alive && (state == IDLE);

  assign accept = in_valid && in_ready;
  assign take   = out_valid && out_ready;

  // Next-state: load a vector in IDLE, clear one bit per handshake in DRAIN
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    empty_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in != 8'd0) begin
            pending_nxt = in;
            state_nxt   = DRAIN;
          end else begin
            empty_nxt = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (take) begin
          pending_nxt = pending & ~(8'd1 << idx);
          if (out_last) state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt   = IDLE;
        pending_nxt = 8'd0;
      end
    endcase
  end

  // State, pending bits and the empty-vector pulse register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 8'd0;
      out_empty <= 1'b0;
      alive     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      out_empty <= empty_nxt;
      alive     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_encoder8to3_serial.sv
// Scoreboard bench: the driver pushes expected indices from a set-bit list model, the monitor pops on each out handshake.
// Directed cases cover reset, ordering, backpressure, zero vector, overlap and reset mid-drain; then random traffic.
// Every wait is bounded; a global watchdog ends the run with a FAIL line if something hangs.
module tb_encoder8to3_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_ready;
  logic       out_empty;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic [3:0] sb[$];       // {last, index}
  int         empty_q[$];  // cycle in which out_empty is expected

  encoder8to3_serial dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in        (in_vec),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (out_idx),
    .out_last  (out_last),
    .out_ready (out_ready),
    .out_empty (out_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Set-bit indices of v in emission order
  function automatic void order_bits(input logic [7:0] v, output int bits[$]);
    bits = {};
    for (int b = 0; b < 8; b++) if (v[b]) bits.push_back(b);
`ifndef ENCODER8TO3_LSB_FIRST_EN
    bits.rsort();
`endif
  endfunction

  function automatic int first_idx(input logic [7:0] v);
    int bits[$];
    order_bits(v, bits);
    return bits[0];
  endfunction

  // Expected response for a vector taken at the coming edge
  function automatic void model_push(input logic [7:0] v);
    int bits[$];
    if (v == 8'd0) begin
      empty_q.push_back(cyc + 1);
      return;
    end
    order_bits(v, bits);
    foreach (bits[j]) sb.push_back({(j == bits.size() - 1), 3'(bits[j])});
  endfunction

  // Drive one cycle of inputs just after a rising edge
  task automatic step(input logic iv, input logic [7:0] v, input logic ordy);
    @(posedge clk);
    #1;
    in_valid  = iv;
    in_vec    = v;
    out_ready = ordy;
    if (iv && in_ready) model_push(v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      step(1'b0, 8'h00, 1'b1);
      n++;
    end
    check("idle_timeout", in_ready, 1);
  endtask

  // Monitor: compare every out handshake and every out_empty pulse against the queues
  logic       pv_valid = 1'b0;
  logic       pv_rdy   = 1'b0;
  logic [2:0] pv_out   = 3'd0;
  logic       pv_last  = 1'b0;
  logic [3:0] exp_item;

  always @(negedge clk) begin
    if (rst) begin
      pv_valid = 1'b0;
    end else begin
      if (pv_valid && !pv_rdy) begin
        check("hold_valid", out_valid, 1);
        check("hold_out", out_idx, pv_out);
        check("hold_last", out_last, pv_last);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_index: got out=%0d with nothing expected (cycle %0d)", out_idx, cyc);
        end else begin
          exp_item = sb.pop_front();
          check("out_idx", out_idx, exp_item[2:0]);
          check("out_last", out_last, exp_item[3]);
        end
      end
      if (out_empty) begin
        if (empty_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_empty: got out_empty=1 with none expected (cycle %0d)", cyc);
        end else begin
          check("empty_cycle", cyc, empty_q.pop_front());
        end
      end
      pv_valid = out_valid;
      pv_rdy   = out_ready;
      pv_out   = out_idx;
      pv_last  = out_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a full vector offered
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'hFF;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_empty", out_empty, 0);
    check("rst_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_vec   = 8'h00;
    step(1'b0, 8'h00, 1'b0);
    check("post_rst_in_ready", in_ready, 1);

    // Basic order and first-index latency
    step(1'b1, 8'b1010_0100, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_first", out_idx, first_idx(8'b1010_0100));
    repeat (3) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("basic_in_ready", in_ready, 1);
    check("basic_valid_low", out_valid, 0);

    // Backpressure holds the first index
    step(1'b1, 8'h81, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_out", out_idx, first_idx(8'h81));
      check("bp_last", out_last, 0);
      step(1'b0, 8'h00, 1'b0);
    end
    wait_idle();

    // Zero vector
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("zero_empty", out_empty, 1);
    check("zero_valid", out_valid, 0);
    check("zero_in_ready", in_ready, 1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("zero_empty_one_cycle", out_empty, 0);

    // Full vector with the next vector already offered
    step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'h01, 1'b1);
      check("overlap_blocked", in_ready, 0);
    end
    step(1'b1, 8'h01, 1'b1);
    check("overlap_taken", in_ready, 1);
    step(1'b0, 8'h00, 1'b1);
    wait_idle();

    // Reset mid-drain discards the remaining indices
    step(1'b1, 8'hF0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    sb.delete();
    empty_q.delete();
    #1;
    check("mid_rst_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    wait_idle();
    repeat (3) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("after_rst_valid", out_valid, 1);
    check("after_rst_out", out_idx, 1);
    check("after_rst_last", out_last, 1);
    wait_idle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      step(1'($urandom_range(0, 1)), v, ($urandom_range(0, 3) != 0));
    end
    step(1'b0, 8'h00, 1'b1);
    wait_idle();
    repeat (2) step(1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("sb_drained", sb.size(), 0);
    check("empty_drained", empty_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
